// File: rtl/input_sequencer.sv
// Input sequencer: collects NUM_DIGITS button presses per round, emitting
// one shift strobe per accepted digit and a verification pulse at the end.
// An idle gap of TIMEOUT_CYCLES in WAIT_PRESS aborts the round.
module input_sequencer #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn1,
  input  logic       btn2,
  output logic       waiting_for_user,
  output logic       digit_bit,
  output logic       start_verification,
  output logic [2:0] entry_count,
  output logic       busy,
  output logic       timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST_COUNT = 3'(NUM_DIGITS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    VERIFY,
    DONE
  } state_t;

  state_t state, state_next;

  logic [1:0]    btn1_sync, btn2_sync;
  logic          b1, b2;
  logic [TW-1:0] timeout_cnt;
  logic          start_ok, accept, timed_out;

  assign b1 = btn1_sync[1];
  assign b2 = btn2_sync[1];

  // Qualify start, digit acceptance and the timeout condition from current state
  always_comb begin
    start_ok  = start && ((state == IDLE) || (state == DONE));
    accept    = (state == WAIT_PRESS) && (b1 ^ b2);
    timed_out = (state == WAIT_PRESS) && !(b1 || b2) && (timeout_cnt == TO_LAST);
  end

  // State register, forced to IDLE asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; any button activity in WAIT_PRESS (one or both) moves
  // on to WAIT_RELEASE so a held or doubled press is only seen once
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (b1 || b2)     state_next = WAIT_RELEASE;
        else if (timed_out) state_next = DONE;
      end
      WAIT_RELEASE: begin
        if (!b1 && !b2)
          state_next = (entry_count == LAST_COUNT) ? VERIFY : WAIT_PRESS;
      end
      VERIFY:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Synchronizers, registered digit strobe, entry and timeout counters, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn1_sync        <= 2'b00;
      btn2_sync        <= 2'b00;
      waiting_for_user <= 1'b0;
      digit_bit        <= 1'b0;
      entry_count      <= 3'd0;
      timeout_cnt      <= '0;
      timeout_err      <= 1'b0;
    end else begin
      btn1_sync        <= {btn1_sync[0], btn1};
      btn2_sync        <= {btn2_sync[0], btn2};
      waiting_for_user <= accept;
      digit_bit        <= accept && b1;
      if (start_ok) begin
        entry_count <= 3'd0;
        timeout_cnt <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (accept) begin
          entry_count <= entry_count + 3'd1;
          timeout_cnt <= '0;
        end else if ((state == WAIT_PRESS) && (timeout_cnt != TO_LAST)) begin
          timeout_cnt <= timeout_cnt + TW'(1);
        end
        if (timed_out) timeout_err <= 1'b1;
      end
    end
  end

  // Moore outputs decoded from state
  always_comb begin
    busy               = (state == WAIT_PRESS) || (state == WAIT_RELEASE) || (state == VERIFY);
    start_verification = (state == VERIFY);
  end

endmodule

// File: tb/tb_input_sequencer.sv
// Scoreboard bench for input_sequencer: stimulus pushes expected strobes
// (digit, count, sample cycle) and verification pulses; a monitor pops them.
module tb_input_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       btn1;
  logic       btn2;
  logic       waiting_for_user;
  logic       digit_bit;
  logic       start_verification;
  logic [2:0] entry_count;
  logic       busy;
  logic       timeout_err;

  typedef struct {
    logic digit;
    int   count;
    int   cyc;
  } exp_t;

  exp_t expQ[$];
  int   verQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   expCount = 0;

  input_sequencer #(.NUM_DIGITS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .btn1(btn1),
    .btn2(btn2),
    .waiting_for_user(waiting_for_user),
    .digit_bit(digit_bit),
    .start_verification(start_verification),
    .entry_count(entry_count),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to check strobe latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic doStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expCount = 0;
  endtask

  // Drive one press of (b1,b2) for 'hold' cycles then release for 'rel';
  // optionally pulse start while the button is held (DUT in WAIT_RELEASE)
  task automatic applyStimulus(input logic b1, input logic b2, input int hold, input int rel,
                               input logic pulseStart, input logic track);
    exp_t e;
    @(negedge clk);
    btn1 = b1;
    btn2 = b2;
    if (track && (b1 ^ b2)) begin
      expCount++;
      e.digit = b1;
      e.count = expCount;
      e.cyc   = cyc + 3;
      expQ.push_back(e);
      if (expCount == 4) verQ.push_back(4);
    end
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      start = (pulseStart && i == 4);
    end
    btn1 = 1'b0;
    btn2 = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes or pulses
  initial begin
    exp_t e;
    int   v;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (waiting_for_user || start_verification)
          checkOutput("strobe_pulse_exclusive", int'(waiting_for_user && start_verification), 0);
        if (waiting_for_user) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_strobe actual=strobe digit %0d count %0d required=no strobe",
                     digit_bit, entry_count);
          end else begin
            e = expQ.pop_front();
            checkOutput("strobe_digit", int'(digit_bit), int'(e.digit));
            checkOutput("strobe_count", int'(entry_count), e.count);
            checkOutput("strobe_latency_cycle", cyc, e.cyc);
          end
        end
        if (start_verification) begin
          if (verQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_verify actual=pulse count %0d required=no pulse", entry_count);
          end else begin
            v = verQ.pop_front();
            checkOutput("verify_count", int'(entry_count), v);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    btn1  = 1'b0;
    btn2  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                int'({waiting_for_user, digit_bit, start_verification, entry_count, busy, timeout_err}), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);

    $display("[TB] round 1: digits 1,0,1,1");
    doStart();
    checkOutput("busy_after_start", int'(busy), 1);
    applyStimulus(1'b1, 1'b0, 5, 5, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5, 5, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5, 5, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5, 5, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("done_busy", int'(busy), 0);
    checkOutput("done_entry_count", int'(entry_count), 4);
    checkOutput("done_timeout_err", int'(timeout_err), 0);

    $display("[TB] round 2: long hold, double press, start during release");
    doStart();
    checkOutput("restart_entry_count", int'(entry_count), 0);
    applyStimulus(1'b1, 1'b0, 200, 5, 1'b0, 1'b1);
    checkOutput("hold_entry_count", int'(entry_count), 1);
    applyStimulus(1'b1, 1'b1, 5, 5, 1'b0, 1'b1);
    checkOutput("double_entry_count", int'(entry_count), 1);
    applyStimulus(1'b0, 1'b1, 5, 5, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5, 5, 1'b1, 1'b1);
    checkOutput("ignored_start_count", int'(entry_count), 3);
    applyStimulus(1'b1, 1'b0, 5, 5, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("round2_busy", int'(busy), 0);
    checkOutput("round2_entry_count", int'(entry_count), 4);

    $display("[TB] timeout round");
    doStart();
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_busy_cycles", n, 16);
    checkOutput("timeout_err_set", int'(timeout_err), 1);
    checkOutput("timeout_entry_count", int'(entry_count), 0);
    doStart();
    checkOutput("timeout_err_cleared", int'(timeout_err), 0);

    $display("[TB] async reset mid-round");
    applyStimulus(1'b1, 1'b0, 5, 5, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5, 5, 1'b0, 1'b1);
    checkOutput("pre_reset_count", int'(entry_count), 2);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
                int'({waiting_for_user, digit_bit, start_verification, entry_count, busy, timeout_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 5, 5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5, 5, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("post_reset_count", int'(entry_count), 0);
    checkOutput("post_reset_busy", int'(busy), 0);

    checkOutput("pending_strobes", expQ.size(), 0);
    checkOutput("pending_verify", verQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
